// File: rtl/iterative_alu_unit_if.sv
// Request/response bundle for the iterative ALU.
// The master drives the operation; the slave (the ALU) returns the result.
interface iterative_alu_unit_if #(
  parameter int N_BITS     = 32,
  parameter int SHAMT_BITS = 5
);
  logic                  start;
  logic [3:0]            ALUOperation;
  logic [N_BITS-1:0]     A;
  logic [N_BITS-1:0]     B;
  logic [SHAMT_BITS-1:0] shamt;
  logic                  busy;
  logic                  done;
  logic [N_BITS-1:0]     ALUResult;
  logic                  Zero;
  logic                  invalid_op;

  modport master (
    output start, ALUOperation, A, B, shamt,
    input  busy, done, ALUResult, Zero, invalid_op
  );

  modport slave (
    input  start, ALUOperation, A, B, shamt,
    output busy, done, ALUResult, Zero, invalid_op
  );
endinterface

// File: rtl/iterative_alu_unit.sv
// Execute unit: 1-cycle logic/arith, 1-bit-per-cycle SLL/SRL.
// Define FAST_SHIFT_EN to use a single-cycle barrel shifter instead.
module iterative_alu_unit #(
  parameter int N_BITS     = 32,
  parameter int SHAMT_BITS = 5
) (
  input logic                  clk,
  input logic                  reset,
  iterative_alu_unit_if.slave  bus
);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_NOR = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_LUI = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [N_BITS-1:0] r_result;
  logic [N_BITS-1:0] w_nxt_result;
  logic              r_zero;
  logic              r_invalid;
  logic              w_nxt_invalid;

`ifndef FAST_SHIFT_EN
  logic [SHAMT_BITS-1:0] r_count;
  logic [SHAMT_BITS-1:0] w_nxt_count;
  logic                  r_left;
  logic                  w_nxt_left;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_invalid <= 1'b0;
`ifndef FAST_SHIFT_EN
      r_count   <= '0;
      r_left    <= 1'b0;
`endif
    end else begin
      r_state   <= w_next_state;
      r_result  <= w_nxt_result;
      r_zero    <= (w_nxt_result == '0);
      r_invalid <= w_nxt_invalid;
`ifndef FAST_SHIFT_EN
      r_count   <= w_nxt_count;
      r_left    <= w_nxt_left;
`endif
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_nxt_result  = r_result;
    w_nxt_invalid = r_invalid;
`ifndef FAST_SHIFT_EN
    w_nxt_count   = r_count;
    w_nxt_left    = r_left;
`endif
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next_state  = DONE;
          w_nxt_invalid = 1'b0;
          case (bus.ALUOperation)
            OP_AND: w_nxt_result = bus.A & bus.B;
            OP_OR:  w_nxt_result = bus.A | bus.B;
            OP_NOR: w_nxt_result = ~(bus.A | bus.B);
            OP_ADD: w_nxt_result = bus.A + bus.B;
            OP_SUB: w_nxt_result = bus.A - bus.B;
            OP_LUI: w_nxt_result = bus.B << 16;
`ifdef FAST_SHIFT_EN
            OP_SLL: w_nxt_result = bus.B << bus.shamt;
            OP_SRL: w_nxt_result = bus.B >> bus.shamt;
`else
            OP_SLL, OP_SRL: begin
              // Load the source; SHIFT walks it one bit per cycle
              w_nxt_result = bus.B;
              if (bus.shamt != '0) begin
                w_nxt_count  = bus.shamt;
                w_nxt_left   = (bus.ALUOperation == OP_SLL);
                w_next_state = SHIFT;
              end
            end
`endif
            default: begin
              w_nxt_result  = '0;
              w_nxt_invalid = 1'b1;
            end
          endcase
        end
      end
`ifndef FAST_SHIFT_EN
      SHIFT: begin
        w_nxt_result = r_left ? (r_result << 1)
                              : (r_result >> 1);
        w_nxt_count  = r_count - SHAMT_BITS'(1);
        if (r_count == SHAMT_BITS'(1))
          w_next_state = DONE;
      end
`endif
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = (r_state == DONE);
  assign bus.ALUResult  = r_result;
  assign bus.Zero       = r_zero;
  assign bus.invalid_op = r_invalid;

endmodule

// File: tb/tb_iterative_alu_unit.sv
// Directed-vector bench for iterative_alu_unit.
// Expected values are hand-computed; latency follows the build option.
module tb_iterative_alu_unit;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  iterative_alu_unit_if #(.N_BITS(32), .SHAMT_BITS(5)) bus ();

  iterative_alu_unit #(.N_BITS(32), .SHAMT_BITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int shift_lat(input int sh);
`ifdef FAST_SHIFT_EN
    return 1;
`else
    return (sh == 0) ? 1 : sh + 1;
`endif
  endfunction

  task automatic run(input string tag,
                     input logic [3:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [4:0] sh,
                     input int exp_lat,
                     input logic [31:0] exp_res,
                     input logic exp_inv);
    int lat;
    bus.start        = 1'b1;
    bus.ALUOperation = op;
    bus.A            = a;
    bus.B            = b;
    bus.shamt        = sh;
    tick();
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    lat = 1;
    while (!bus.done && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, bus.ALUResult, exp_res);
    chk({tag, "_zero"}, {31'b0, bus.Zero}, {31'b0, exp_res == 0});
    chk({tag, "_inv"}, {31'b0, bus.invalid_op}, {31'b0, exp_inv});
    tick();
    chk({tag, "_pulse"}, {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    int t;
    n_chk            = 0;
    n_pass           = 0;
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.ALUOperation = 4'd0;
    bus.A            = '0;
    bus.B            = '0;
    bus.shamt        = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_res",  bus.ALUResult, 32'd0);
    chk("rst_zero", {31'b0, bus.Zero}, 32'd1);
    chk("rst_inv",  {31'b0, bus.invalid_op}, 32'd0);

    // Reset in the middle of a 20-step shift
    bus.start        = 1'b1;
    bus.ALUOperation = 4'd6;
    bus.B            = 32'h0000_0001;
    bus.shamt        = 5'd20;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
`ifndef FAST_SHIFT_EN
    chk("mid_busy", {31'b0, bus.busy}, 32'd1);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_busy", {31'b0, bus.busy}, 32'd0);
    chk("mr_done", {31'b0, bus.done}, 32'd0);
    chk("mr_res",  bus.ALUResult, 32'd0);
    chk("mr_zero", {31'b0, bus.Zero}, 32'd1);
    run("post_rst", 4'd1, 32'h3, 32'h4, 5'd0, 1, 32'h7, 1'b0);

    run("add_ovf", 4'd3, 32'h7FFF_FFFF, 32'h1, 5'd0, 1,
        32'h8000_0000, 1'b0);
    run("sub_eq", 4'd4, 32'd5, 32'd5, 5'd0, 1, 32'h0, 1'b0);
    run("sub_neg", 4'd4, 32'd0, 32'd1, 5'd0, 1,
        32'hFFFF_FFFF, 1'b0);
    run("and", 4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 1,
        32'hF000_F000, 1'b0);
    run("nor", 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 1,
        32'h000F_000F, 1'b0);
    run("lui", 4'd5, 32'h0, 32'h0000_1234, 5'd0, 1,
        32'h1234_0000, 1'b0);
    run("sll31", 4'd6, 32'h0, 32'h0000_0001, 5'd31, shift_lat(31),
        32'h8000_0000, 1'b0);
    run("srl4", 4'd7, 32'h0, 32'h8000_0000, 5'd4, shift_lat(4),
        32'h0800_0000, 1'b0);
    run("srl0", 4'd7, 32'h0, 32'h0000_1234, 5'd0, shift_lat(0),
        32'h0000_1234, 1'b0);
    run("sll_all", 4'd6, 32'h0, 32'hFFFF_FFFF, 5'd8, shift_lat(8),
        32'hFFFF_FF00, 1'b0);

    // start held high through an SLL while A changes
    bus.start        = 1'b1;
    bus.ALUOperation = 4'd6;
    bus.A            = 32'h0;
    bus.B            = 32'h0000_0001;
    bus.shamt        = 5'd3;
    tick();
    bus.A = 32'hDEAD_BEEF;
    t = 1;
    while (!bus.done && t < 100) begin
      tick();
      t++;
    end
    chk("hs_lat", t, shift_lat(3));
    chk("hs_res", bus.ALUResult, 32'h0000_0008);
    bus.ALUOperation = 4'd3;
    bus.A            = 32'd10;
    bus.B            = 32'd20;
    tick();
    chk("hs_idle_busy", {31'b0, bus.busy}, 32'd0);
    chk("hs_idle_done", {31'b0, bus.done}, 32'd0);
    chk("hs_hold", bus.ALUResult, 32'h0000_0008);
    tick();
    bus.start = 1'b0;
    chk("hs2_done", {31'b0, bus.done}, 32'd1);
    chk("hs2_res", bus.ALUResult, 32'd30);
    tick();
    chk("hs2_pulse", {31'b0, bus.done}, 32'd0);

    run("inv", 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1,
        32'h0, 1'b1);
    tick();
    chk("inv_hold", {31'b0, bus.invalid_op}, 32'd1);
    run("inv_clr", 4'd1, 32'h1, 32'h2, 5'd0, 1, 32'h3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
